// File: rtl/ekf_stage_sequencer_pkg.sv
// Shared encodings for the EKF stage sequencer: command types, one-hot
// stage request codes and the sequencer FSM states.
package ekf_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    CMD_PREDICT = 2'd0,
    CMD_NEWLM   = 2'd1,
    CMD_UPDATE  = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_type_e;

  localparam logic [2:0] STAGE_NONE    = 3'b000;
  localparam logic [2:0] STAGE_PREDICT = 3'b001;
  localparam logic [2:0] STAGE_NEWLM   = 3'b010;
  localparam logic [2:0] STAGE_UPDATE  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Maps a command type onto the one-hot stage it requests.
  function automatic logic [2:0] stageOf(input cmd_type_e t);
    case (t)
      CMD_PREDICT: stageOf = STAGE_PREDICT;
      CMD_NEWLM:   stageOf = STAGE_NEWLM;
      CMD_UPDATE:  stageOf = STAGE_UPDATE;
      default:     stageOf = STAGE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ekf_stage_sequencer_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags. The head entry
// is presented combinationally so the sequencer can inspect it before popping.
module ekf_stage_sequencer_cmd_fifo
  import ekf_stage_sequencer_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          doPush;
  logic          doPop;

  assign doPush  = push_i && !full_q;
  assign doPop   = pop_i && !empty_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!doPush && doPop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointers, occupancy and flags; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/ekf_stage_sequencer.sv
// EKF stage sequencer: queues predict/newlm/update commands and issues them
// one at a time to the RSA top with a valid/ready start and a ready-based
// done handshake, tracking the landmark count and sticky error flags.
module ekf_stage_sequencer
  import ekf_stage_sequencer_pkg::*;
#(
  parameter int RSA_DW     = 32,
  parameter int ROW_LEN    = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_DW      = 16
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [ROW_LEN-1:0] cmd_lk,
  input  logic [RSA_DW-1:0]  cmd_d0,
  input  logic [RSA_DW-1:0]  cmd_d1,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_DW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_DW-1:0]  phi,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic               err_cmd,
  output logic               err_timeout,
  output logic               busy
);

  localparam int CW = 2 + ROW_LEN + 2*RSA_DW;
  localparam logic [ROW_LEN-1:0] LM_MAX = '1;
  localparam logic [TO_DW-1:0]   TO_MAX = '1;

  logic [CW-1:0]      fifoWdata;
  logic [CW-1:0]      fifoRdata;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               popReq;
  logic               pushReq;

  cmd_type_e          headType;
  logic [ROW_LEN-1:0] headLk;
  logic [RSA_DW-1:0]  headD0;
  logic [RSA_DW-1:0]  headD1;

  state_e             state_q, state_d;
  logic [2:0]         stage_q, stage_d;
  logic [ROW_LEN-1:0] lk_q, lk_d;
  logic [RSA_DW-1:0]  vlr_q, vlr_d;
  logic [RSA_DW-1:0]  alpha_q, alpha_d;
  logic [RSA_DW-1:0]  rk_q, rk_d;
  logic [RSA_DW-1:0]  phi_q, phi_d;
  logic [ROW_LEN-1:0] lmNum_q, lmNum_d;
  logic               errCmd_q, errCmd_d;
  logic               errTo_q, errTo_d;
  logic [TO_DW-1:0]   toCnt_q, toCnt_d;
  logic               stageRdyHit;

  assign cmd_ready = sys_rst && !fifoFull;
  assign pushReq   = cmd_valid && cmd_ready;
  assign fifoWdata = {cmd_type, cmd_lk, cmd_d0, cmd_d1};

  assign headType = cmd_type_e'(fifoRdata[CW-1 -: 2]);
  assign headLk   = fifoRdata[2*RSA_DW +: ROW_LEN];
  assign headD0   = fifoRdata[RSA_DW +: RSA_DW];
  assign headD1   = fifoRdata[0 +: RSA_DW];

  assign stageRdyHit = (stage_q & stage_rdy) != 3'b000;

  ekf_stage_sequencer_cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) cmd_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .wdata_i (fifoWdata),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Next-state logic: pop/validate in IDLE, handshake through ISSUE/ACK/RUN.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    lk_d      = lk_q;
    vlr_d     = vlr_q;
    alpha_d   = alpha_q;
    rk_d      = rk_q;
    phi_d     = phi_q;
    lmNum_d   = lmNum_q;
    errCmd_d  = errCmd_q;
    errTo_d   = errTo_q;
    toCnt_d   = '0;
    popReq    = 1'b0;
    stage_val = STAGE_NONE;

    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          popReq = 1'b1;
          if ((headType == CMD_ILLEGAL) ||
              (headType == CMD_UPDATE && headLk >= lmNum_q) ||
              (headType == CMD_NEWLM && lmNum_q == LM_MAX)) begin
            errCmd_d = 1'b1;
          end else begin
            lk_d    = headLk;
            stage_d = stageOf(headType);
            state_d = ST_ISSUE;
            if (headType == CMD_PREDICT) begin
              vlr_d   = headD0;
              alpha_d = headD1;
            end else begin
              rk_d  = headD0;
              phi_d = headD1;
            end
          end
        end
      end

      ST_ISSUE: begin
        stage_val = stage_q;
        if (stageRdyHit) state_d = ST_ACK;
      end

      ST_ACK: begin
        toCnt_d = (toCnt_q == TO_MAX) ? toCnt_q : toCnt_q + TO_DW'(1);
        if (!stageRdyHit) begin
          state_d = ST_RUN;
        end else if (toCnt_d == TO_MAX) begin
          errTo_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        toCnt_d = (toCnt_q == TO_MAX) ? toCnt_q : toCnt_q + TO_DW'(1);
        if (stageRdyHit) begin
          state_d = ST_IDLE;
          if (stage_q == STAGE_NEWLM && lmNum_q != LM_MAX) begin
            lmNum_d = lmNum_q + ROW_LEN'(1);
          end
        end else if (toCnt_d == TO_MAX) begin
          errTo_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers; reset abandons any in-flight stage.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= STAGE_NONE;
      lk_q     <= '0;
      vlr_q    <= '0;
      alpha_q  <= '0;
      rk_q     <= '0;
      phi_q    <= '0;
      lmNum_q  <= '0;
      errCmd_q <= 1'b0;
      errTo_q  <= 1'b0;
      toCnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      lk_q     <= lk_d;
      vlr_q    <= vlr_d;
      alpha_q  <= alpha_d;
      rk_q     <= rk_d;
      phi_q    <= phi_d;
      lmNum_q  <= lmNum_d;
      errCmd_q <= errCmd_d;
      errTo_q  <= errTo_d;
      toCnt_q  <= toCnt_d;
    end
  end

  assign l_k          = lk_q;
  assign vlr          = vlr_q;
  assign alpha        = alpha_q;
  assign rk           = rk_q;
  assign phi          = phi_q;
  assign landmark_num = lmNum_q;
  assign err_cmd      = errCmd_q;
  assign err_timeout  = errTo_q;
  assign busy         = (state_q != ST_IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// Scoreboard bench for the EKF stage sequencer with a small RSA stage model.
module tb_ekf_stage_sequencer;

  localparam int RSA_DW  = 32;
  localparam int ROW_LEN = 10;
  localparam int DEPTH   = 4;
  localparam int TO_DW   = 4;

  localparam logic [1:0] T_PRE = 2'd0;
  localparam logic [1:0] T_NEW = 2'd1;
  localparam logic [1:0] T_UPD = 2'd2;
  localparam logic [1:0] T_ILL = 2'd3;

  logic               clk;
  logic               sys_rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [ROW_LEN-1:0] cmd_lk;
  logic [RSA_DW-1:0]  cmd_d0;
  logic [RSA_DW-1:0]  cmd_d1;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  logic [ROW_LEN-1:0] l_k;
  logic [RSA_DW-1:0]  vlr;
  logic [RSA_DW-1:0]  alpha;
  logic [RSA_DW-1:0]  rk;
  logic [RSA_DW-1:0]  phi;
  logic [ROW_LEN-1:0] landmark_num;
  logic               err_cmd;
  logic               err_timeout;
  logic               busy;

  typedef struct packed {
    logic [2:0]         stage;
    logic [ROW_LEN-1:0] lk;
    logic [RSA_DW-1:0]  vlr;
    logic [RSA_DW-1:0]  alpha;
    logic [RSA_DW-1:0]  rk;
    logic [RSA_DW-1:0]  phi;
  } exp_t;

  exp_t              expQ[$];
  logic [RSA_DW-1:0] mVlr, mAlpha, mRk, mPhi;
  int                vectors = 0;
  int                miscompares = 0;
  int                rdyMode = 0;

  ekf_stage_sequencer #(
    .RSA_DW     (RSA_DW),
    .ROW_LEN    (ROW_LEN),
    .FIFO_DEPTH (DEPTH),
    .TO_DW      (TO_DW)
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_lk       (cmd_lk),
    .cmd_d0       (cmd_d0),
    .cmd_d1       (cmd_d1),
    .stage_val    (stage_val),
    .stage_rdy    (stage_rdy),
    .l_k          (l_k),
    .vlr          (vlr),
    .alpha        (alpha),
    .rk           (rk),
    .phi          (phi),
    .landmark_num (landmark_num),
    .err_cmd      (err_cmd),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Offers one command (called at a negedge), waits for acceptance and, when
  // the command should be issued, records the expected issue snapshot.
  task automatic applyStimulus(input logic [1:0] t, input logic [ROW_LEN-1:0] lk,
                               input logic [RSA_DW-1:0] d0, input logic [RSA_DW-1:0] d1,
                               input bit issues);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_lk    = lk;
    cmd_d0    = d0;
    cmd_d1    = d1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_accept: cmd_ready stayed 0, required 1 within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    if (issues) begin
      if (t == T_PRE) begin
        mVlr = d0; mAlpha = d1;
      end else begin
        mRk = d0; mPhi = d1;
      end
      e.stage = (t == T_PRE) ? 3'b001 : (t == T_NEW) ? 3'b010 : 3'b100;
      e.lk    = lk;
      e.vlr   = mVlr;
      e.alpha = mAlpha;
      e.rk    = mRk;
      e.phi   = mPhi;
      expQ.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((busy || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_drained"}, 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_stage_val"}, 64'(stage_val), 64'd0);
    checkOutput({name, "_l_k"}, 64'(l_k), 64'd0);
    checkOutput({name, "_vlr"}, 64'(vlr), 64'd0);
    checkOutput({name, "_alpha"}, 64'(alpha), 64'd0);
    checkOutput({name, "_rk"}, 64'(rk), 64'd0);
    checkOutput({name, "_phi"}, 64'(phi), 64'd0);
    checkOutput({name, "_landmark_num"}, 64'(landmark_num), 64'd0);
    checkOutput({name, "_err_cmd"}, 64'(err_cmd), 64'd0);
    checkOutput({name, "_err_timeout"}, 64'(err_timeout), 64'd0);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  // RSA stage model: idle-ready high; after a start it stays high 2 cycles,
  // drops for 10 cycles (running) and returns high (done). Modes 1/2 pin it.
  initial begin
    int  k;
    bit  active;
    k = 0;
    active = 1'b0;
    stage_rdy = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      if (!sys_rst) begin
        active = 1'b0;
        k = 0;
        stage_rdy = 3'b111;
      end else if (rdyMode == 1) begin
        stage_rdy = 3'b000;
      end else if (rdyMode == 2) begin
        stage_rdy = 3'b111;
      end else if (active) begin
        k++;
        if (k == 2) begin
          stage_rdy = 3'b000;
        end else if (k == 12) begin
          stage_rdy = 3'b111;
          active = 1'b0;
        end
      end else begin
        stage_rdy = 3'b111;
        if (stage_val != 3'b000) begin
          active = 1'b1;
          k = 0;
        end
      end
    end
  end

  // Monitor: on every start handshake compare against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sys_rst && stage_val != 3'b000 && (stage_val & stage_rdy) != 3'b000) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_issue: stage_val=%b, required no issue", stage_val);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_stage_val", 64'(stage_val), 64'(e.stage));
          checkOutput("issue_l_k", 64'(l_k), 64'(e.lk));
          checkOutput("issue_vlr", 64'(vlr), 64'(e.vlr));
          checkOutput("issue_alpha", 64'(alpha), 64'(e.alpha));
          checkOutput("issue_rk", 64'(rk), 64'(e.rk));
          checkOutput("issue_phi", 64'(phi), 64'(e.phi));
        end
      end
    end
  end

  // Hard stop in case something escapes the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int cnt;
    sys_rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = 2'd0;
    cmd_lk = '0;
    cmd_d0 = '0;
    cmd_d1 = '0;
    mVlr = '0; mAlpha = '0; mRk = '0; mPhi = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    sys_rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

    $display("[TB] single predict, latency and completion");
    applyStimulus(T_PRE, 10'd0, 32'h0001_0000, 32'h0000_4000, 1'b1);
    checkOutput("busy_after_push", 64'(busy), 64'd1);
    checkOutput("latency_n1", 64'(stage_val), 64'd0);
    @(negedge clk);
    checkOutput("latency_n2", 64'(stage_val), 64'b001);
    @(negedge clk);
    checkOutput("stage_val_one_cycle", 64'(stage_val), 64'd0);
    waitIdle("predict");
    checkOutput("predict_no_timeout", 64'(err_timeout), 64'd0);

    $display("[TB] three newlm then update");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(T_NEW, ROW_LEN'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1);
      waitIdle("newlm");
      checkOutput("landmark_num_inc", 64'(landmark_num), 64'(i + 1));
    end
    applyStimulus(T_UPD, 10'd2, 32'h0000_AAAA, 32'h0000_BBBB, 1'b1);
    waitIdle("update");
    checkOutput("update_err_cmd", 64'(err_cmd), 64'd0);
    checkOutput("update_landmark_num", 64'(landmark_num), 64'd3);

    $display("[TB] discarded commands");
    applyStimulus(T_UPD, 10'd5, 32'hDEAD_0001, 32'hDEAD_0002, 1'b0);
    applyStimulus(T_ILL, 10'd1, 32'hDEAD_0003, 32'hDEAD_0004, 1'b0);
    waitIdle("discard");
    checkOutput("discard_err_cmd", 64'(err_cmd), 64'd1);
    checkOutput("discard_landmark_num", 64'(landmark_num), 64'd3);

    $display("[TB] FIFO fill with stage stalled");
    rdyMode = 1;
    applyStimulus(T_PRE, 10'd7, 32'h0000_0011, 32'h0000_0012, 1'b1);
    applyStimulus(T_NEW, 10'd3, 32'h0000_0021, 32'h0000_0022, 1'b1);
    applyStimulus(T_UPD, 10'd1, 32'h0000_0031, 32'h0000_0032, 1'b1);
    applyStimulus(T_PRE, 10'd9, 32'h0000_0041, 32'h0000_0042, 1'b1);
    applyStimulus(T_NEW, 10'd4, 32'h0000_0051, 32'h0000_0052, 1'b1);
    checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("stalled_stage_val", 64'(stage_val), 64'b001);
    rdyMode = 0;
    waitIdle("drain");
    checkOutput("drain_landmark_num", 64'(landmark_num), 64'd5);
    checkOutput("drain_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("[TB] completion timeout");
    rdyMode = 2;
    applyStimulus(T_PRE, 10'd4, 32'h0000_1234, 32'h0000_5678, 1'b1);
    cnt = 0;
    while (stage_val == 3'b000 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("timeout_issue_seen", 64'(stage_val), 64'b001);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (err_timeout) break;
      cnt++;
    end
    checkOutput("timeout_ack_cycles", 64'(cnt), 64'd15);
    checkOutput("timeout_flag", 64'(err_timeout), 64'd1);
    checkOutput("timeout_idle", 64'(busy), 64'd0);
    checkOutput("timeout_landmark_num", 64'(landmark_num), 64'd5);
    rdyMode = 0;
    applyStimulus(T_UPD, 10'd4, 32'h0000_0061, 32'h0000_0062, 1'b1);
    waitIdle("after_timeout");
    checkOutput("timeout_sticky", 64'(err_timeout), 64'd1);

    $display("[TB] reset during RUN");
    applyStimulus(T_PRE, 10'd6, 32'h0000_0071, 32'h0000_0072, 1'b1);
    applyStimulus(T_NEW, 10'd7, 32'h0000_0081, 32'h0000_0082, 1'b1);
    applyStimulus(T_PRE, 10'd8, 32'h0000_0091, 32'h0000_0092, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    sys_rst = 1'b0;
    expQ.delete();
    mVlr = '0; mAlpha = '0; mRk = '0; mPhi = '0;
    @(negedge clk);
    checkResetState("midrun_reset");
    sys_rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    checkOutput("post_reset_no_issue", 64'(stage_val), 64'd0);
    checkOutput("post_reset_landmark_num", 64'(landmark_num), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ekf_stage_sequencer.md
EKF_STAGE_SEQUENCER -- requirements
Module: ekf_stage_sequencer

Interface
REQ-001 SHALL have parameter RSA_DW, default 32, meaning width of every data word.
REQ-002 SHALL have parameter ROW_LEN, default 10, meaning width of landmark index and landmark count.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TO_DW, default 16, meaning width of the completion-timeout counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, FIFO not full.
REQ-009 SHALL have port cmd_type, input, 2, 0=predict, 1=newlm, 2=update, 3=illegal.
REQ-010 SHALL have port cmd_lk, input, ROW_LEN, landmark index.
REQ-011 SHALL have port cmd_d0, input, RSA_DW, vlr (predict) or rk (newlm/update).
REQ-012 SHALL have port cmd_d1, input, RSA_DW, alpha (predict) or phi (newlm/update).
REQ-013 SHALL have port stage_val, output, 3, one-hot stage request to the RSA top: bit0 predict, bit1 newlm, bit2 update.
REQ-014 SHALL have port stage_rdy, input, 3, per-stage ready from the RSA top.
REQ-015 SHALL have ports l_k (ROW_LEN), vlr, alpha, rk, phi (RSA_DW each), outputs, registered operands to the RSA top.
REQ-016 SHALL have port landmark_num, output, ROW_LEN, current map landmark count.
REQ-017 SHALL have ports err_cmd and err_timeout, outputs, 1 each, sticky error flags.
REQ-018 SHALL have port busy, output, 1, high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-019 SHALL push a command when cmd_valid && cmd_ready; cmd_ready = !full.
REQ-020 SHALL run the FSM states IDLE, ISSUE, ACK, RUN.
REQ-021 IDLE: if FIFO not empty, pop head, load operand registers, go ISSUE next cycle.
REQ-022 Operand load: predict drives vlr/alpha; newlm and update drive rk/phi; unused operand registers hold their previous value; l_k loaded for all types.
REQ-023 SHALL discard cmd_type 3 and update commands with cmd_lk >= landmark_num at pop, set err_cmd, stay IDLE.
REQ-024 ISSUE: assert the one stage_val bit; transfer when that bit of stage_val and stage_rdy are both high; then deassert stage_val and go ACK.
REQ-025 ACK: wait for the issued stage_rdy bit low (stage started), then go RUN.
REQ-026 RUN: wait for the issued stage_rdy bit high (stage done), then go IDLE; on newlm completion increment landmark_num.
REQ-027 landmark_num SHALL saturate at 2^ROW_LEN-1; a newlm at saturation sets err_cmd and is discarded at pop.
REQ-028 SHALL count cycles in ACK and RUN; reaching 2^TO_DW-1 sets err_timeout and returns to IDLE without incrementing landmark_num.
REQ-029 Simultaneous push and pop on a full FIFO SHALL not occur (cmd_ready low); on an empty FIFO push lands, pop waits one cycle.
REQ-030 Operand outputs SHALL stay stable from ISSUE entry until the next pop.
REQ-031 Minimum issue latency: command accepted in cycle n -> stage_val high in cycle n+2.

Reset
REQ-032 On sys_rst low at a clock edge: FSM IDLE, FIFO empty, stage_val 0, all operands 0, landmark_num 0, err flags 0, timeout counter 0; cmd_ready 0 during reset, 1 from the first cycle after.
REQ-033 Reset mid-operation SHALL abandon the in-flight stage with no handshake cleanup.

Structure
REQ-034 Shared package SHALL hold the cmd_type encodings, the one-hot stage constants, and the FSM state enumeration.
REQ-035 The command FIFO SHALL be one sub-module, cmd_fifo (synchronous, registered full/empty, width 2+ROW_LEN+2*RSA_DW).

Verification
REQ-036 Push predict (d0=0x00010000, d1=0x00004000); rdy drop in 2 cycles, return after 10 -> stage_val=001 one cycle at n+2, vlr/alpha match, busy low after return.
REQ-037 Three newlm then update lk=2 -> landmark_num 1,2,3; update issued with stage_val=100, l_k=2, err_cmd stays 0.
REQ-038 Update lk=5 with landmark_num=3, and cmd_type=3 -> both discarded, err_cmd=1, stage_val never asserted.
REQ-039 Push 5 commands back-to-back with stage_rdy held low -> cmd_ready low after 4th accepted entry (first already popped, so 5 accepted), order preserved on drain.
REQ-040 stage_rdy held high after issue (never drops) with TO_DW=4 -> err_timeout=1 after 15 cycles in ACK, FSM IDLE, next command proceeds.
REQ-041 sys_rst low during RUN -> next cycle all outputs at reset values, queued commands lost.
